demux_sched: RTL and testbench
==============================

DEMUX_SCHED -- requirements
Module: demux_sched

Interface
REQ-001 Parameter: LEN_W, 4, width of burst-length field; legal range 2..8.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req_valid  input  1  requester offers a burst.
REQ-005 Port: req_ready  output  1  scheduler can accept a burst.
REQ-006 Port: req_dst  input  2  destination sink 0..3; ignored when DEMUX_SCHED_RR_EN is defined.
REQ-007 Port: req_len  input  LEN_W  burst length minus one; enable held for req_len+1 counted cycles.
REQ-008 Port: sink_ready  input  4  per-sink ready; bit n belongs to demux output n.
REQ-009 Port: a  output  1  demux select MSB; equals latched dst[1].
REQ-010 Port: b  output  1  demux select LSB; equals latched dst[0].
REQ-011 Port: e  output  1  demux enable; registered.
REQ-012 Port: busy  output  1  high whenever state is not IDLE.
REQ-013 Port: done  output  1  one-cycle pulse at burst completion.

Function
REQ-014 States SHALL be IDLE, WAIT, ACTIVE, GAP; req_ready = (state==IDLE), combinational from state.
REQ-015 Accept SHALL occur on a clk edge with req_valid && req_ready; dst and len latched, a/b updated at that same edge, state -> WAIT.
REQ-016 req_valid while not IDLE SHALL be ignored; no latch, no state change.
REQ-017 WAIT: e=0; if sink_ready[dst] sampled 1, next state ACTIVE and e=1 from the following cycle.
REQ-018 ACTIVE: remaining count decrements by one on each edge where sink_ready[dst]=1; when count==0 at such an edge, next state GAP.
REQ-019 ACTIVE with sink_ready[dst]=0 SHALL return to WAIT, e=0 next cycle, remaining count preserved (no cycle counted).
REQ-020 req_len=0 SHALL yield exactly one enabled, counted cycle; req_len=2^LEN_W-1 SHALL yield 2^LEN_W cycles without counter wrap.
REQ-021 GAP: e=0, done=1 for exactly this one cycle; next state IDLE unconditionally.
REQ-022 a and b SHALL change only at an accept edge and never while e=1; they hold last value through GAP and IDLE.
REQ-023 Minimum accept-to-first-e latency SHALL be 2 cycles (accept edge, WAIT cycle); back-to-back bursts separated by at least GAP plus IDLE (2 cycles e=0).

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, e=0, done=0, a=0, b=0, count=0, busy=0, req_ready=1, regardless of clock.
REQ-025 Reset asserted mid-burst SHALL abort it with no done pulse; first accept after release starts clean.
REQ-026 Round-robin pointer (when compiled in) SHALL reset to 0.

Configuration
REQ-027 Macro DEMUX_SCHED_RR_EN defined: req_dst ignored; each accepted burst targets pointer value, pointer increments mod 4 (3 wraps to 0) at the accept edge.
REQ-028 Macro DEMUX_SCHED_RR_EN undefined: destination = req_dst; no pointer register exists.

Verification
REQ-029 Reset release, req_valid=1, req_dst=2, req_len=3, sink_ready=4'b0100 -> a=1,b=0 after accept; e high exactly 4 cycles starting 2 cycles after accept; done pulse next cycle; req_ready back 1 after.
REQ-030 req_dst=1, req_len=5, sink_ready[1] dropped for 3 cycles after 2 enabled cycles -> e low 3 cycles, then 4 more enabled cycles, total 6; a/b stay 0/1 throughout.
REQ-031 req_len=0, sink_ready=4'b1111 -> single e cycle; req_len=4'hF -> 16 e cycles, done once.
REQ-032 rst_n pulsed low during ACTIVE (count=2) -> e, busy drop asynchronously, no done; new burst dst=3 runs normally.
REQ-033 DEMUX_SCHED_RR_EN defined, five bursts with req_dst=0 -> targets 0,1,2,3,0; without macro -> all target 0.
REQ-034 req_valid held high while busy with changing req_dst -> no a/b change until IDLE; only one accept per completed burst.

Source files
------------

// File: rtl/demux_sched.sv
// demux_sched: steers one burst at a time onto a 1-of-4 demux (select a/b, enable e).
// Latency: accept edge -> WAIT cycle -> e high, so at least 2 cycles; GAP + IDLE separate bursts.
// Backpressure: req_ready only in IDLE; sink_ready[dst] low stalls the burst, keeping its count.
// Build option: define DEMUX_SCHED_RR_EN to ignore req_dst and rotate destinations 0,1,2,3,0...
module demux_sched #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_dst,
  input  logic [LEN_W-1:0] req_len,
  input  logic [3:0]       sink_ready,
  output logic             a,
  output logic             b,
  output logic             e,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, GAP} state_t;

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [1:0]       acc_dst;
  logic             sel_rdy;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  // a/b hold the latched destination, so they double as the sink index.
  assign sel_rdy   = sink_ready[{a, b}];

`ifdef DEMUX_SCHED_RR_EN
  logic [1:0] rr_ptr;

  assign acc_dst = rr_ptr;

  // Advance the round-robin pointer on every accepted burst; wraps 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 2'd0;
    end else if (req_valid && req_ready) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end
`else
  assign acc_dst = req_dst;
`endif

  // Burst sequencer: cnt holds remaining beats minus one, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a     <= 1'b0;
      b     <= 1'b0;
      e     <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            {a, b} <= acc_dst;
            cnt    <= req_len;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (sel_rdy) begin
            state <= ACTIVE;
            e     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (sel_rdy) begin
            if (cnt == '0) begin
              state <= GAP;
              e     <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - LEN_W'(1);
            end
          end else begin
            // Sink stalled: drop enable, keep remaining count, re-arm in WAIT.
            state <= WAIT;
            e     <= 1'b0;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          e     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_sched.sv
// tb_demux_sched: randomized + directed stimulus with a queue scoreboard for demux_sched.
// A burst is modelled as (destination, beats = len+1); a beat is an edge with e and the
// selected sink ready. The monitor pops one expectation per done pulse.
module tb_demux_sched;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_dst;
  logic [LEN_W-1:0] req_len;
  logic [3:0]       sink_ready;
  logic             a, b, e, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] dst;
    int         beats;
  } exp_t;

  exp_t sb[$];
  int   rr_ptr = 0;
  bit   exp_ready = 1'b1;
  int   beats = 0;
  int   lat = 0;
  bit   lat_active = 1'b0;
  bit   wait_rdy = 1'b0;

  demux_sched #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dst(req_dst), .req_len(req_len), .sink_ready(sink_ready),
    .a(a), .b(b), .e(e), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: samples at negedge, i.e. the values the next posedge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_ready  = 1'b1;
      beats      = 0;
      lat_active = 1'b0;
      rr_ptr     = 0;
    end else begin
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, !exp_ready);
      chk("e_with_done", e & done, 0);
      if (sb.size() > 0 && !exp_ready) chk("select_ab", {a, b}, sb[0].dst);
      if (lat_active) begin
        lat++;
        if (lat == 1) begin
          chk("wait_cycle_e", e, 0);
          wait_rdy = sink_ready[{a, b}];
        end else begin
          chk("first_e_latency", e, wait_rdy);
          lat_active = 1'b0;
        end
      end
      if (e && sink_ready[{a, b}]) beats++;
      if (done) begin
        chk("done_has_pending", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          chk("beats", beats, sb[0].beats);
          chk("gap_e_low", e, 0);
          void'(sb.pop_front());
        end
        beats     = 0;
        exp_ready = 1'b1;
      end else if (req_valid && exp_ready) begin
        exp_t x;
`ifdef DEMUX_SCHED_RR_EN
        x.dst  = 2'(rr_ptr);
        rr_ptr = (rr_ptr + 1) % 4;
`else
        x.dst  = req_dst;
`endif
        x.beats = int'(req_len) + 1;
        sb.push_back(x);
        exp_ready  = 1'b0;
        beats      = 0;
        lat        = 0;
        lat_active = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] d, input logic [LEN_W-1:0] l);
    bit ok = 1'b0;
    req_dst   = d;
    req_len   = l;
    req_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_timeout", ok, 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (rnd) begin
        @(posedge clk);
        #2;
        sink_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      end
    end
    chk("done_timeout", ok, 1);
    step();
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
    step();
  endtask

  task automatic wait_beats(input int n);
    int seen = 0;
    for (int i = 0; i < 200 && seen < n; i++) begin
      @(negedge clk);
      if (e && sink_ready[{a, b}]) seen++;
    end
    chk("beat_wait_timeout", seen, n);
  endtask

  initial begin
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    req_dst    = 2'd0;
    req_len    = '0;
    sink_ready = 4'h0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_e", e, 0);
    chk("rst_done", done, 0);
    chk("rst_ab", {a, b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic burst to sink 2, four beats.
    sink_ready = 4'b0100;
    send(2'd2, 4'd3);
    wait_done(1'b0);

    // Burst to sink 1 stalled for three cycles after two beats.
    sink_ready = 4'b0010;
    send(2'd1, 4'd5);
    wait_beats(2);
    step();
    sink_ready = 4'b0000;
    step(); step(); step();
    sink_ready = 4'b0010;
    wait_done(1'b0);

    // Length boundaries.
    sink_ready = 4'hF;
    send(2'd0, 4'd0);
    wait_done(1'b0);
    send(2'd3, 4'hF);
    wait_done(1'b0);

    // Reset in the middle of an active burst.
    send(2'd0, 4'd5);
    wait_beats(3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_e", e, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ab", {a, b}, 0);
    chk("midrst_ready", req_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    step();
    send(2'd3, 4'd2);
    wait_done(1'b0);

    // Five bursts requesting sink 0 (rotates when round-robin is built in).
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 4'd1);
      wait_done(1'b0);
    end

    // Randomized bursts with random sink stalls.
    for (int i = 0; i < 25; i++) begin
      sink_ready = 4'($urandom);
      send(2'($urandom), 4'($urandom));
      wait_done(1'b1);
    end

    // req_valid held high with a changing destination while busy.
    sink_ready = 4'hF;
    req_valid  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      req_dst = 2'($urandom);
      req_len = 4'($urandom_range(0, 3));
      step();
    end
    req_valid = 1'b0;
    wait_idle();

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
